// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction fetch unit; optional counters via IFETCH_STATS_EN
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [5:0]  id_opcode,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_flushed
`endif
);

   // Fetch pointer and run flag
   logic [31:0] pc_q, pc_d;
   logic        run_q, run_d;
   // Accepted-but-unreturned requests, and how many of them are stale
   logic [1:0]  out_q, out_d;
   logic [1:0]  drop_q, drop_d;
   // Addresses of in-flight requests, oldest in slot 0
   logic [31:0] aq_q [2];
   logic [31:0] aq_d [2];
   // Two-entry instruction buffer {instr, pc}
   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_instr_d [2];
   logic [31:0] fifo_pc_q [2];
   logic [31:0] fifo_pc_d [2];
   logic        head_q, head_d;
   logic [1:0]  cnt_q, cnt_d;

   logic accept, resp, pop, discard, push;
   logic wslot, aslot;

   // Handshake decode and the credit rule bounding outstanding + buffered to two
   always_comb begin
      imem_req  = run_q && !redirect && (({1'b0, out_q} + {1'b0, cnt_q}) < 3'd2);
      imem_addr = pc_q;
      accept    = imem_req && imem_rdy;
      // A response with nothing outstanding is a leftover from before a reset
      resp      = imem_rvalid && (out_q != 2'd0);
      pop       = id_valid && id_ready;
      discard   = resp && (drop_q != 2'd0);
      push      = resp && !discard && !redirect;
      wslot     = head_q ^ cnt_q[0];
      aslot     = out_q[0] && !resp;
   end

   // Decode-facing view of the buffer head; zero whenever nothing is presented
   always_comb begin
      id_valid    = (cnt_q != 2'd0);
      id_instr    = id_valid ? fifo_instr_q[head_q] : 32'd0;
      id_pc       = id_valid ? fifo_pc_q[head_q] : 32'd0;
      id_opcode   = id_instr[31:26];
      id_pc_plus4 = id_valid ? (id_pc + 32'd4) : 32'd0;
   end

   // Next-state: PC, request tracking, drop accounting and buffer updates
   always_comb begin
      run_d        = 1'b1;
      pc_d         = pc_q;
      out_d        = out_q + {1'b0, accept} - {1'b0, resp};
      drop_d       = drop_q;
      aq_d         = aq_q;
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;
      head_d       = head_q;
      cnt_d        = cnt_q;

      // Address queue shifts out the answered request and appends the new one
      if (resp) begin
         aq_d[0] = aq_q[1];
      end
      if (accept) begin
         aq_d[aslot] = pc_q;
         pc_d        = pc_q + 32'd4;
      end

      if (redirect) begin
         // Everything still in flight after this edge belongs to the old path
         pc_d   = redirect_pc & 32'hFFFF_FFFC;
         drop_d = out_d;
         cnt_d  = 2'd0;
      end else begin
         if (discard) begin
            drop_d = drop_q - 2'd1;
         end
         if (push) begin
            fifo_instr_d[wslot] = imem_rdata;
            fifo_pc_d[wslot]    = aq_q[0];
         end
         head_d = head_q ^ pop;
         cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q            <= RESET_PC;
         run_q           <= 1'b0;
         out_q           <= 2'd0;
         drop_q          <= 2'd0;
         aq_q[0]         <= 32'd0;
         aq_q[1]         <= 32'd0;
         fifo_instr_q[0] <= 32'd0;
         fifo_instr_q[1] <= 32'd0;
         fifo_pc_q[0]    <= 32'd0;
         fifo_pc_q[1]    <= 32'd0;
         head_q          <= 1'b0;
         cnt_q           <= 2'd0;
      end else begin
         pc_q         <= pc_d;
         run_q        <= run_d;
         out_q        <= out_d;
         drop_q       <= drop_d;
         aq_q         <= aq_d;
         fifo_instr_q <= fifo_instr_d;
         fifo_pc_q    <= fifo_pc_d;
         head_q       <= head_d;
         cnt_q        <= cnt_d;
      end
   end

`ifdef IFETCH_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_flushed_q, stat_flushed_d;

   // Pops count as fetched; flushed covers cleared entries, same-edge responses and drops
   always_comb begin
      stat_fetched_d = stat_fetched_q + {31'd0, pop};
      if (redirect) begin
         stat_flushed_d = stat_flushed_q + {30'd0, cnt_q} - {31'd0, pop} + {31'd0, resp};
      end else begin
         stat_flushed_d = stat_flushed_q + {31'd0, discard};
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched_q <= 32'd0;
         stat_flushed_q <= 32'd0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_flushed_q <= stat_flushed_d;
      end
   end

   assign stat_fetched = stat_fetched_q;
   assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [5:0]  id_opcode;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
`ifdef IFETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_flushed;
`endif

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdy    (imem_rdy),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_opcode   (id_opcode),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4)
`ifdef IFETCH_STATS_EN
      ,
      .stat_fetched (stat_fetched),
      .stat_flushed (stat_flushed)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Memory model: in-order responses; stale 0 = live, 1 = old path, 2 = pre-reset
   logic [31:0] mem_addr [$];
   int          mem_due [$];
   int          mem_stale [$];
   // Scoreboard of PCs expected at decode, in order
   logic [31:0] exp_q [$];
   logic [31:0] model_pc;
   int          cyc = 0;
   int          lat = 1;
   bit          last_req;
   int          pop_count = 0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h8C00_0000;
   endfunction

   function automatic int live_count();
      int n = 0;
      foreach (mem_stale[i]) if (mem_stale[i] != 2) n++;
      return n;
   endfunction

   task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
      bit          resp, acc, pp;
      logic [31:0] e, a;
      int          st;
      @(negedge clk);
      imem_rdy    = rdy;
      id_ready    = idr;
      redirect    = redir;
      redirect_pc = rpc;
      resp        = (mem_addr.size() > 0) && (mem_due[0] <= cyc);
      imem_rvalid = resp;
      imem_rdata  = resp ? mem_data(mem_addr[0]) : 32'h0;
      #2;
      acc      = imem_req && imem_rdy;
      pp       = id_valid && id_ready;
      last_req = imem_req;
      checks++;
      if (id_valid !== (exp_q.size() != 0)) begin
         failures++;
         $display("FAIL id_valid cyc=%0d got=%b want=%b", cyc, id_valid, exp_q.size() != 0);
      end
      if (id_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q[0];
         a = mem_data(e);
         checks++;
         if (id_pc !== e) begin
            failures++;
            $display("FAIL id_pc cyc=%0d got=%h want=%h", cyc, id_pc, e);
         end
         checks++;
         if (id_instr !== a) begin
            failures++;
            $display("FAIL id_instr cyc=%0d got=%h want=%h", cyc, id_instr, a);
         end
         checks++;
         if (id_opcode !== a[31:26]) begin
            failures++;
            $display("FAIL id_opcode cyc=%0d got=%h want=%h", cyc, id_opcode, a[31:26]);
         end
         checks++;
         if (id_pc_plus4 !== e + 32'd4) begin
            failures++;
            $display("FAIL id_pc_plus4 cyc=%0d got=%h want=%h", cyc, id_pc_plus4, e + 32'd4);
         end
      end
      if (redir) begin
         checks++;
         if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_in_redirect cyc=%0d got=%b want=0", cyc, imem_req);
         end
      end
      if (acc) begin
         checks++;
         if (imem_addr !== model_pc) begin
            failures++;
            $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, model_pc);
         end
      end
      checks++;
      if (live_count() + exp_q.size() > 2) begin
         failures++;
         $display("FAIL credit cyc=%0d got=%0d want<=2", cyc, live_count() + exp_q.size());
      end
      @(posedge clk);
      if (pp && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         pop_count++;
      end
      if (resp) begin
         st = mem_stale.pop_front();
         a  = mem_addr.pop_front();
         void'(mem_due.pop_front());
         if (st == 0 && !redir) exp_q.push_back(a);
      end
      if (acc) begin
         mem_addr.push_back(model_pc);
         mem_due.push_back(cyc + lat);
         mem_stale.push_back(0);
         model_pc = model_pc + 32'd4;
      end
      if (redir) begin
         exp_q.delete();
         foreach (mem_stale[i]) if (mem_stale[i] != 2) mem_stale[i] = 1;
         model_pc = rpc & 32'hFFFF_FFFC;
      end
      cyc++;
   endtask

   task automatic drive_idle();
      imem_rdy    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      id_ready    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      model_pc = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_id_valid got=%b want=0", id_valid); end
      checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL rst_id_instr got=%h want=0", id_instr); end
      checks++; if (id_opcode !== 6'h0) begin failures++; $display("FAIL rst_id_opcode got=%h want=0", id_opcode); end
      checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_id_pc got=%h want=0", id_pc); end
      checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rst_id_pc_plus4 got=%h want=0", id_pc_plus4); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rel_req_before_run got=%b want=0", imem_req); end
      step(0, 0, 0, 32'h0);
      checks++; if (last_req !== 1'b1) begin failures++; $display("FAIL run_second_cycle got=%b want=1", last_req); end
   endtask

   task automatic test_stream();
      int p0;
      lat = 1;
      repeat (4) step(1, 0, 0, 32'h0);
      #2;
      checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL first_pc got=%h want=0", id_pc); end
      checks++; if (id_opcode !== 6'b100011) begin failures++; $display("FAIL first_opcode got=%b want=100011", id_opcode); end
      repeat (8) step(1, 1, 0, 32'h0);
      p0 = pop_count;
      repeat (12) step(1, 1, 0, 32'h0);
      checks++;
      if (pop_count - p0 < 8) begin
         failures++;
         $display("FAIL stream_rate got=%0d want>=8", pop_count - p0);
      end
   endtask

   task automatic test_backpressure();
      lat = 1;
      repeat (10) step(1, 0, 0, 32'h0);
      #2;
      checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b want=1", id_valid); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got=%b want=0", imem_req); end
      repeat (12) step(1, 1, 0, 32'h0);
   endtask

   task automatic test_redirect_latency();
      bit found = 0;
      lat = 3;
      for (int i = 0; i < 10 && live_count() < 2; i++) step(1, 1, 0, 32'h0);
      checks++; if (live_count() != 2) begin failures++; $display("FAIL rd_two_inflight got=%0d want=2", live_count()); end
      step(1, 1, 1, 32'h0000_0103);
      for (int i = 0; i < 15 && !found; i++) begin
         step(1, 1, 0, 32'h0);
         #2;
         if (id_valid === 1'b1) begin
            found = 1;
            checks++;
            if (id_pc !== 32'h100) begin failures++; $display("FAIL rd_first_pc got=%h want=00000100", id_pc); end
         end
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL rd_timeout got=none want=id_valid");
      end
      repeat (10) step(1, 1, 0, 32'h0);
   endtask

   task automatic test_redirect_pop_resp();
      lat = 1;
      for (int i = 0; i < 10 && !(exp_q.size() == 1 && mem_addr.size() == 1); i++) step(1, 1, 0, 32'h0);
      checks++;
      if (!(exp_q.size() == 1 && mem_addr.size() == 1)) begin
         failures++;
         $display("FAIL rpr_setup got=%0d/%0d want=1/1", exp_q.size(), mem_addr.size());
      end
      step(1, 1, 1, 32'h0000_0200);
      #2;
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rpr_flushed got=%b want=0", id_valid); end
      repeat (12) step(1, 1, 0, 32'h0);
   endtask

   task automatic test_wrap();
      bit found = 0;
      lat = 1;
      step(1, 1, 1, 32'hFFFF_FFF8);
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 0, 32'h0);
         #2;
         if (id_valid === 1'b1 && id_pc === 32'hFFFF_FFFC && !found) begin
            found = 1;
            checks++;
            if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h want=0", id_pc_plus4); end
         end
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL wrap_seen got=none want=FFFFFFFC");
      end
   endtask

   task automatic test_reset_midstream();
      bit found = 0;
      lat = 3;
      step(1, 1, 1, 32'h0000_0040);
      for (int i = 0; i < 10 && live_count() < 2; i++) step(1, 1, 0, 32'h0);
      checks++; if (live_count() != 2) begin failures++; $display("FAIL mr_two_inflight got=%0d want=2", live_count()); end
      #1;
      rst_n = 1'b0;
      drive_idle();
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mr_req got=%b want=0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL mr_addr got=%h want=0", imem_addr); end
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL mr_id_valid got=%b want=0", id_valid); end
      checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL mr_id_pc got=%h want=0", id_pc); end
`ifdef IFETCH_STATS_EN
      checks++; if (stat_fetched !== 32'h0) begin failures++; $display("FAIL mr_stat_fetched got=%h want=0", stat_fetched); end
      checks++; if (stat_flushed !== 32'h0) begin failures++; $display("FAIL mr_stat_flushed got=%h want=0", stat_flushed); end
`endif
      exp_q.delete();
      foreach (mem_stale[i]) begin
         mem_stale[i] = 2;
         mem_due[i]   = cyc;
      end
      model_pc = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, 0, 32'h0);
      checks++; if (last_req !== 1'b1) begin failures++; $display("FAIL mr_restart_req got=%b want=1", last_req); end
      step(0, 1, 0, 32'h0);
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 0, 32'h0);
         #2;
         if (id_valid === 1'b1 && !found) begin
            found = 1;
            checks++;
            if (id_pc !== 32'h0) begin failures++; $display("FAIL mr_first_pc got=%h want=0", id_pc); end
         end
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL mr_timeout got=none want=id_valid");
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_latency();
      test_redirect_pop_resp();
      test_wrap();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
